logic_pipe: RTL
===============

Name: logic_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the RISC-V ALU; generalises the single-function combinational XOR operation.
- Supports eight bitwise ops selected per transaction.
- Valid/ready handshakes on input and output, configurable pipeline depth, and a zero flag.
- Sits between the ALU operand mux and the result writeback mux.

Parameters:
- WIDTH, 64, operand/result width in bits (supported range 8..128).
- STAGES, 2, number of register stages, which is also the no-stall latency in cycles (supported range 1..4).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has an operation on A/B/op.
- in_ready  output  1  unit accepts the operation this cycle.
- op  input  3  operation select (encoding below).
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- out_valid  output  1  result/zero hold a completed operation.
- out_ready  input  1  downstream consumes the result this cycle.
- result  output  WIDTH  operation result.
- zero  output  1  high when result == 0.

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits become 0, all stage data registers become 0, so out_valid=0, result=0 and zero=0. in_ready is 1 as soon as rst_n is high.
- Reset mid-operation: all in-flight operations are discarded, with no partial output.
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 XNOR
  - 100 ANDN (A & ~B)
  - 101 ORN (A | ~B)
  - 110 NOR
  - 111 NAND
- Width rules: pure bitwise; no carry or sign handling. Two's-complement operands behave bitwise, e.g. -1111 XOR 2222 = -3321.
- Compute point: the op is evaluated combinationally from A/B/op and captured into stage 0 on acceptance (in_valid & in_ready). zero is computed at the same point and carried alongside the result.
- Pipeline: stages 0..STAGES-1, each holding valid, result and zero. The last stage drives the outputs.
- Advance rule: stage i may load when it is empty, or when stage i+1 can load / the output is consumed (last stage: out_ready). This is a fully occupiable pipeline with no bubbles under backpressure.
- in_ready = !valid[0] | advance[0]. This is a combinational ready chain from out_ready; it is acceptable at STAGES <= 4.
- Throughput and latency:
  - 1 op/cycle when out_ready is held high.
  - Latency from acceptance to out_valid is exactly STAGES cycles.
- Backpressure: with out_ready low, the pipeline holds up to STAGES ops. in_ready falls once all stages are valid.
- Output stability: result/zero stay stable while out_valid & !out_ready.
- Simultaneous events: acceptance and consumption in the same cycle on a full pipeline is allowed; occupancy stays STAGES.
- Ordering: ops complete strictly in acceptance order; no drop or duplication.
- Non-accepted input: when in_valid=0, A/B/op are ignored and there are no X-propagation requirements on them.

Decomposition:
- Shared package alu_pkg:
  - op encoding localparams: LOGIC_AND .. LOGIC_NAND.
  - typedef logic_op_t (3-bit).
- Sub-module logic_op_comb, purely combinational, WIDTH-parametrised:
  - inputs A, B, op.
  - outputs result, zero.
  - reused by the ALU's single-cycle path.
- logic_pipe instantiates logic_op_comb once and implements the STAGES-deep handshake pipeline with a generate loop.

Test Plan:
- XOR, STAGES=2, out_ready=1: A=123, B=456, op=010 -> out_valid exactly 2 cycles after acceptance, result=435, zero=0. Repeat with A=-1111, B=2222 -> result=-3321. Repeat with A=-3333, B=-4444 -> result=7263.
- All ops, back-to-back inputs, one per cycle, A=123, B=456 in op order -> results in order:
  - AND 72
  - OR 507
  - XOR 435
  - XNOR ~435
  - ANDN 51
  - ORN ~384
  - NOR ~507
  - NAND ~72
  - Required: one result per cycle, no gaps.
- Zero flag: XOR with A=B=0xDEADBEEF -> result=0, zero=1. AND with A=0xF0, B=0x0F -> zero=1. OR with A=0, B=1 -> zero=0.
- Backpressure: out_ready=0 while streaming 5 ops -> in_ready drops after STAGES acceptances. Then raise out_ready -> all 5 results emerge in order; result is unchanged during the stall; no loss or duplication.
- Reset mid-flight: 2 ops in the pipeline, pulse rst_n low asynchronously, between clock edges -> out_valid=0, result=0 and zero=0 immediately. After release, in_ready=1 and no stale result appears.
- Parameter sweep: STAGES=1 and STAGES=4, WIDTH=32 -> latency equals STAGES. -1 XOR 0 = 0xFFFFFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: bitwise-logic op encoding used by the logic unit
// and the single-cycle ALU path.
package alu_pkg;

  localparam int unsigned LOGIC_OP_W = 3;

  typedef logic [LOGIC_OP_W-1:0] logic_op_t;

  localparam logic_op_t LOGIC_AND  = 3'b000;
  localparam logic_op_t LOGIC_OR   = 3'b001;
  localparam logic_op_t LOGIC_XOR  = 3'b010;
  localparam logic_op_t LOGIC_XNOR = 3'b011;
  localparam logic_op_t LOGIC_ANDN = 3'b100;
  localparam logic_op_t LOGIC_ORN  = 3'b101;
  localparam logic_op_t LOGIC_NOR  = 3'b110;
  localparam logic_op_t LOGIC_NAND = 3'b111;

endpackage : alu_pkg

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise logic op with zero detect; shared between the
// pipelined logic unit and the single-cycle ALU path.
module logic_op_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic_op_t        op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    unique case (op)
      LOGIC_AND:  result = A & B;
      LOGIC_OR:   result = A | B;
      LOGIC_XOR:  result = A ^ B;
      LOGIC_XNOR: result = ~(A ^ B);
      LOGIC_ANDN: result = A & ~B;
      LOGIC_ORN:  result = A | ~B;
      LOGIC_NOR:  result = ~(A | B);
      LOGIC_NAND: result = ~(A & B);
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule : logic_op_comb

// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit: op evaluated at the input, then carried through
// STAGES valid/ready register stages with no bubbles under backpressure.
module logic_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic_op_t        op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned LAST = STAGES - 1;

  logic [WIDTH-1:0]  op_res_c;
  logic              op_zero_c;

  logic [STAGES-1:0] occ_c;
  logic [STAGES-1:0] adv_c;

  logic              valid_q [STAGES];
  logic              valid_d [STAGES];
  logic [WIDTH-1:0]  res_q   [STAGES];
  logic [WIDTH-1:0]  res_d   [STAGES];
  logic              zero_q  [STAGES];
  logic              zero_d  [STAGES];

  logic_op_comb #(
    .WIDTH (WIDTH)
  ) u_op (
    .A      (A),
    .B      (B),
    .op     (op),
    .result (op_res_c),
    .zero   (op_zero_c)
  );

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_res;
    logic             src_zero;

    if (i == 0) begin : g_src_in
      assign src_valid = in_valid;
      assign src_res   = op_res_c;
      assign src_zero  = op_zero_c;
    end else begin : g_src_prev
      assign src_valid = valid_q[i-1];
      assign src_res   = res_q[i-1];
      assign src_zero  = zero_q[i-1];
    end

    assign occ_c[i] = valid_q[i];
    // A stage can load if the output is consumed or any stage from here down is empty.
    assign adv_c[i] = out_ready | ~(&occ_c[LAST:i]);

    always_comb begin
      valid_d[i] = valid_q[i];
      res_d[i]   = res_q[i];
      zero_d[i]  = zero_q[i];
      if (adv_c[i]) begin
        valid_d[i] = src_valid;
        if (src_valid) begin
          res_d[i]  = src_res;
          zero_d[i] = src_zero;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[i] <= 1'b0;
        res_q[i]   <= '0;
        zero_q[i]  <= 1'b0;
      end else begin
        valid_q[i] <= valid_d[i];
        res_q[i]   <= res_d[i];
        zero_q[i]  <= zero_d[i];
      end
    end
  end

  assign in_ready  = adv_c[0];
  assign out_valid = valid_q[LAST];
  assign result    = res_q[LAST];
  assign zero      = zero_q[LAST];

endmodule : logic_pipe
